// File: rtl/button_ctrl.sv
// Multi-channel push-button controller: sync, debounce, press/release/long-press pulses,
// per-channel toggle latch and an up/down LED event counter. The release pulse output is
// named release_ev because "release" is a reserved word in SystemVerilog.
module button_ctrl #(
  parameter int unsigned N_BUTTONS       = 2,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000,
  parameter int unsigned LED_WIDTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press,
  output logic [N_BUTTONS-1:0] release_ev,
  output logic [N_BUTTONS-1:0] long_press,
  output logic [N_BUTTONS-1:0] toggle,
  output logic [LED_WIDTH-1:0] led
);

  localparam int unsigned DcW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HcW    = $clog2(LONG_CYCLES) + 1;
  localparam int unsigned DecIdx = (N_BUTTONS > 1) ? 1 : 0;
  localparam logic [DcW-1:0] DcMax = DcW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HcW-1:0] HcMax = HcW'(LONG_CYCLES);

  logic [N_BUTTONS-1:0] raw, sync1, sync2;
  logic [N_BUTTONS-1:0] pressed_d, press_d, release_d, long_d, toggle_d;
  logic [N_BUTTONS-1:0] fired_q, fired_d;
  logic [DcW-1:0]       dc_q [N_BUTTONS];
  logic [DcW-1:0]       dc_d [N_BUTTONS];
  logic [HcW-1:0]       hc_q [N_BUTTONS];
  logic [HcW-1:0]       hc_d [N_BUTTONS];
  logic [LED_WIDTH-1:0] led_d;
  logic                 inc, dec;

  assign raw = ACTIVE_LOW ? ~buttons : buttons;

  always_comb begin
    pressed_d = pressed;
    long_d    = '0;
    fired_d   = fired_q;
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      dc_d[i] = '0;
      hc_d[i] = hc_q[i];
      if (sync2[i] != pressed[i]) begin
        if (dc_q[i] == DcMax) pressed_d[i] = sync2[i];
        else                  dc_d[i] = dc_q[i] + DcW'(1);
      end
      if (!pressed_d[i]) begin
        hc_d[i]    = '0;
        fired_d[i] = 1'b0;
      end else if (!pressed[i]) begin
        hc_d[i] = HcW'(1);
      end else if (hc_q[i] != HcMax) begin
        hc_d[i] = hc_q[i] + HcW'(1);
      end
      // fired_q limits the pulse to once per press while hc sits saturated
      long_d[i] = pressed[i] && pressed_d[i] && (hc_q[i] == HcMax) && !fired_q[i];
      if (long_d[i]) fired_d[i] = 1'b1;
    end
  end

  assign press_d   = pressed_d & ~pressed;
  assign release_d = ~pressed_d & pressed;
  assign toggle_d  = toggle ^ press_d;

  assign inc = press[0];
  assign dec = (N_BUTTONS > 1) && press[DecIdx];

  always_comb begin
    led_d = led;
    if (|long_press)       led_d = '0;
    else if (inc && !dec)  led_d = led + LED_WIDTH'(1);
    else if (dec && !inc)  led_d = led - LED_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= '0;
      sync2      <= '0;
      pressed    <= '0;
      press      <= '0;
      release_ev <= '0;
      long_press <= '0;
      toggle     <= '0;
      fired_q    <= '0;
      led        <= '0;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        dc_q[i] <= '0;
        hc_q[i] <= '0;
      end
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      pressed    <= pressed_d;
      press      <= press_d;
      release_ev <= release_d;
      long_press <= long_d;
      toggle     <= toggle_d;
      fired_q    <= fired_d;
      led        <= led_d;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        dc_q[i] <= dc_d[i];
        hc_q[i] <= hc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_ctrl.sv
// Scoreboard bench for button_ctrl: stimulus queues expected events, a monitor checks them.
module tb_button_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] buttons;
  logic [1:0] pressed, press, release_ev, long_press, toggle;
  logic [3:0] led;

  button_ctrl #(
    .N_BUTTONS      (2),
    .ACTIVE_LOW     (1'b1),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16),
    .LED_WIDTH      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buttons   (buttons),
    .pressed   (pressed),
    .press     (press),
    .release_ev(release_ev),
    .long_press(long_press),
    .toggle    (toggle),
    .led       (led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [1:0] pr, rl, lp, pd, tg;
    logic [3:0] led;
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic [1:0] pr, input logic [1:0] rl,
                      input logic [1:0] lp, input logic [1:0] pd, input logic [1:0] tg,
                      input logic [3:0] l);
    ev_t e;
    e.at = at; e.pr = pr; e.rl = rl; e.lp = lp; e.pd = pd; e.tg = tg; e.led = l;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero();
    chk("rst_pressed", 32'(pressed), 0);
    chk("rst_press", 32'(press), 0);
    chk("rst_release", 32'(release_ev), 0);
    chk("rst_long", 32'(long_press), 0);
    chk("rst_toggle", 32'(toggle), 0);
    chk("rst_led", 32'(led), 0);
  endtask

  // Short press of the channels in m (active-low pins), then release.
  task automatic tap(input logic [1:0] m, input logic [1:0] tg, input logic [3:0] l);
    int c;
    buttons = ~m;
    c = cyc;
    push(c + 6, m, 2'b00, 2'b00, m, tg, l);
    step(8);
    buttons = 2'b11;
    c = cyc;
    push(c + 6, 2'b00, m, 2'b00, 2'b00, tg, l);
    step(12);
  endtask

  // Monitor: every event pulse pops one record; led is checked on the following cycle.
  initial begin
    ev_t        e;
    logic       led_pend;
    logic [3:0] led_exp;
    led_pend = 1'b0;
    led_exp  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst !== 1'b1) begin
        led_pend = 1'b0;
        continue;
      end
      if (led_pend) begin
        chk("led_after_event", 32'(led), 32'(led_exp));
        led_pend = 1'b0;
      end
      if (|{press, release_ev, long_press}) begin
        if (q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_event: got press=%b release=%b long=%b expected none (cycle %0d)",
                   press, release_ev, long_press, cyc);
        end else begin
          e = q.pop_front();
          chk("event_cycle", 32'(cyc), 32'(e.at));
          chk("press", 32'(press), 32'(e.pr));
          chk("release", 32'(release_ev), 32'(e.rl));
          chk("long_press", 32'(long_press), 32'(e.lp));
          chk("pressed", 32'(pressed), 32'(e.pd));
          chk("toggle", 32'(toggle), 32'(e.tg));
          led_exp  = e.led;
          led_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    rst     = 1'b0;
    buttons = 2'b11;
    #1;
    check_zero();
    step(3);
    rst = 1'b1;
    step(4);

    // Bounce shorter than the debounce window: nothing happens.
    buttons = 2'b10; step(3);
    buttons = 2'b11; step(1);
    buttons = 2'b10; step(3);
    buttons = 2'b11; step(10);
    chk("bounce_pressed", 32'(pressed), 0);
    chk("bounce_led", 32'(led), 0);
    chk("bounce_toggle", 32'(toggle), 0);

    // Long hold on channel 1: dec wraps to 15, long press 16 cycles later clears led.
    c = cyc;
    buttons = 2'b01;
    push(c + 6, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 4'd15);
    push(c + 22, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 4'd0);
    step(40);
    c = cyc;
    buttons = 2'b11;
    push(c + 6, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 4'd0);
    step(12);

    // Single presses of channel 0 up to led=5.
    tap(2'b01, 2'b11, 4'd1);
    tap(2'b01, 2'b10, 4'd2);
    tap(2'b01, 2'b11, 4'd3);
    tap(2'b01, 2'b10, 4'd4);
    tap(2'b01, 2'b11, 4'd5);

    // Simultaneous inc and dec: led holds, both toggles flip.
    tap(2'b11, 2'b00, 4'd5);

    // Wrap from a fresh reset.
    step(1);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(4);
    for (int i = 1; i <= 16; i++) tap(2'b01, {1'b0, i[0]}, 4'(i));
    chk("wrap_led", 32'(led), 0);
    chk("wrap_toggle", 32'(toggle), 0);

    // Reach led=3 with channel 0 held, then reset mid-hold.
    tap(2'b01, 2'b01, 4'd1);
    tap(2'b01, 2'b00, 4'd2);
    c = cyc;
    buttons = 2'b10;
    push(c + 6, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 4'd3);
    step(9);
    #2;
    rst = 1'b0;
    #1;
    check_zero();
    step(3);
    rst = 1'b1;
    c = cyc;
    push(c + 6, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 4'd1);
    step(9);
    c = cyc;
    buttons = 2'b11;
    push(c + 6, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 4'd1);
    step(12);

    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
